tt_rr_arbiter: RTL and testbench
================================

TT_RR_ARBITER -- requirements
Module: tt_rr_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 8, giving the number of requesters; legal range 2..32, and it need not be a power of two.
REQ-002 The block SHALL have parameter IDX_W, default $clog2(NUM_REQ), giving the encoded grant index width.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port i_reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port i_req, input, NUM_REQ bits: per-requester request level.
REQ-006 The block SHALL have port i_mask, input, NUM_REQ bits: per-requester disable; 1 makes that requester ineligible.
REQ-007 The block SHALL have port i_ready, input, 1 bit: the downstream resource accepts the current beat.
REQ-008 The block SHALL have port i_last, input, 1 bit: the current beat is the final beat of the granted transaction.
REQ-009 The block SHALL have port o_valid, output, 1 bit: a grant is active.
REQ-010 The block SHALL have port o_gnt, output, NUM_REQ bits: one-hot grant vector.
REQ-011 The block SHALL have port o_gnt_idx, output, IDX_W bits: encoded index of the granted requester.

Function
REQ-012 The block SHALL implement a two-state FSM: IDLE (no grant) and LOCK (grant held).
REQ-013 Eligibility SHALL be computed as elig = i_req & ~i_mask, sampled only when the FSM arbitrates.
REQ-014 The winner SHALL be the first eligible index at or after the priority pointer ptr, searching upward and wrapping from NUM_REQ-1 to 0; indices >= NUM_REQ are never selected.
REQ-015 In IDLE with elig != 0, the next edge SHALL register the winner into o_gnt_idx, set o_valid=1 and enter LOCK; grant latency is 1 cycle from the request being sampled.
REQ-016 In IDLE with elig == 0, the block SHALL stay in IDLE with o_valid=0.
REQ-017 A beat SHALL complete on any edge where o_valid & i_ready = 1; a transaction SHALL complete on a beat with i_last=1.
REQ-018 In LOCK, beats with i_last=0 SHALL leave the grant, index and ptr unchanged.
REQ-019 In LOCK, changes to i_req, i_mask or i_last without i_ready SHALL be ignored, including deassertion of i_req or assertion of i_mask for the granted requester.
REQ-020 On transaction completion, ptr SHALL become (o_gnt_idx+1) mod NUM_REQ, wrapping at NUM_REQ rather than 2^IDX_W.
REQ-021 On transaction completion, if elig != 0 in that cycle, the same edge SHALL grant the winner searched from the new ptr and stay in LOCK, giving back-to-back grants with no idle bubble.
REQ-022 On transaction completion with elig == 0, the block SHALL return to IDLE with o_valid=0.
REQ-023 o_gnt SHALL be the one-hot decode of o_gnt_idx qualified by o_valid: exactly one bit set when o_valid=1, all zero when o_valid=0.
REQ-024 With a single eligible requester, it SHALL be re-granted on every completion regardless of ptr.
REQ-025 The maximum wait for a continuously eligible requester SHALL be NUM_REQ-1 completed transactions.

Reset
REQ-026 While i_reset_n=0, the block SHALL be in IDLE with ptr=0, o_valid=0, o_gnt=0 and o_gnt_idx=0, applied asynchronously.
REQ-027 Reset asserted mid-transaction SHALL drop the grant immediately; no beat is considered complete.
REQ-028 After reset deassertion, the first arbitration SHALL start from index 0.

Verification (NUM_REQ=4 unless noted)
REQ-029 The bench SHALL cover: reset release, i_req=4'b1010, i_mask=0 -> one cycle later o_valid=1, o_gnt_idx=1, o_gnt=4'b0010.
REQ-030 The bench SHALL cover: i_req=4'b1111 held, i_ready=1, i_last=1 every cycle -> grants 0,1,2,3,0 on consecutive cycles with o_valid never dropping.
REQ-031 The bench SHALL cover: a 3-beat transaction granted to idx 2 (i_last on beat 3, i_ready low for 2 cycles in between), with req[2] dropped and mask[2] set mid-transfer -> o_gnt_idx stays 2 until the i_last beat, then ptr=3.
REQ-032 The bench SHALL cover: i_req=4'b1111, i_mask=4'b0101 -> grants alternate 1,3,1,3; with i_req=4'b0101 -> o_valid stays 0.
REQ-033 The bench SHALL cover: NUM_REQ=5, grant at idx 4 completes with i_req=5'b11111 -> ptr wraps to 0 and next o_gnt_idx=0 (never 5..7).
REQ-034 The bench SHALL cover: i_reset_n pulsed low while o_valid=1 at idx 3 -> outputs zero within the same cycle, and after release i_req=4'b1001 -> grant idx 0.

Source files
------------

// File: rtl/tt_rr_arbiter.sv
// Round-robin arbiter that locks a grant for a multi-beat transaction.
// The priority pointer advances past the winner when its last beat completes.
module tt_rr_arbiter #(
    parameter int NUM_REQ = 8,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [NUM_REQ-1:0] i_mask,
    input  logic               i_ready,
    input  logic               i_last,
    output logic               o_valid,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_gnt_idx
);

    localparam int SPAN = 1 << IDX_W;
    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [0:0]       r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_gnt_idx;

    logic [0:0]       w_state_nxt;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [SPAN-1:0]  w_elig;
    logic             w_done;
    logic [IDX_W-1:0] w_ptr_inc;
    logic [IDX_W-1:0] w_search_ptr;
    logic             w_found;
    logic [IDX_W-1:0] w_win_idx;

    // Padding to a power of two keeps every candidate index in range of the select.
    assign w_elig       = SPAN'(i_req & ~i_mask);
    assign w_done       = (r_state == ST_LOCK) && i_ready && i_last;
    assign w_ptr_inc    = (r_gnt_idx == LAST_IDX) ? '0 : r_gnt_idx + IDX_W'(1);
    assign w_search_ptr = (r_state == ST_LOCK) ? w_ptr_inc : r_ptr;

    // Walk from the farthest offset back to the pointer so the nearest eligible index is written last.
    always_comb begin : search
        logic [IDX_W:0] w_sum;
        // NOTE: every always_comb output gets a default first, otherwise a missed path infers a latch.
        w_found   = 1'b0;
        w_win_idx = '0;
        w_sum     = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            w_sum = {1'b0, w_search_ptr} + (IDX_W+1)'(off);
            if (w_sum >= NUM_REQ_W) begin
                w_sum = w_sum - NUM_REQ_W;
            end
            if (w_elig[w_sum[IDX_W-1:0]]) begin
                w_found   = 1'b1;
                w_win_idx = w_sum[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_idx_nxt   = r_gnt_idx;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_LOCK;
                    w_idx_nxt   = w_win_idx;
                end
            end
            ST_LOCK: begin
                if (w_done) begin
                    w_ptr_nxt = w_ptr_inc;
                    if (w_found) begin
                        w_idx_nxt = w_win_idx;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_gnt_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_gnt_idx <= w_idx_nxt;
        end
    end

    assign o_valid   = (r_state == ST_LOCK);
    assign o_gnt_idx = r_gnt_idx;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_gnt
        assign o_gnt[g] = o_valid && (r_gnt_idx == IDX_W'(g));
    end

endmodule

// File: tb/tb_tt_rr_arbiter.sv
// Scoreboard bench for tt_rr_arbiter: a 4-requester instance for most scenarios
// and a 5-requester instance for the non-power-of-two pointer wrap.
module tb_tt_rr_arbiter;

    logic clk;

    logic       rst4_n, ready4, last4, valid4;
    logic [3:0] req4, mask4, gnt4;
    logic [1:0] idx4;

    logic       rst5_n, ready5, last5, valid5;
    logic [4:0] req5, mask5, gnt5;
    logic [2:0] idx5;

    typedef struct {
        string tag;
        bit    on5;
        bit    valid;
        int    idx;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    tt_rr_arbiter #(.NUM_REQ(4)) u_dut4 (
        .i_clk     (clk),
        .i_reset_n (rst4_n),
        .i_req     (req4),
        .i_mask    (mask4),
        .i_ready   (ready4),
        .i_last    (last4),
        .o_valid   (valid4),
        .o_gnt     (gnt4),
        .o_gnt_idx (idx4)
    );

    tt_rr_arbiter #(.NUM_REQ(5)) u_dut5 (
        .i_clk     (clk),
        .i_reset_n (rst5_n),
        .i_req     (req5),
        .i_mask    (mask5),
        .i_ready   (ready5),
        .i_last    (last5),
        .o_valid   (valid5),
        .o_gnt     (gnt5),
        .o_gnt_idx (idx5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic compare();
        exp_t        e;
        logic [31:0] exp_gnt;
        e       = sb_q.pop_front();
        exp_gnt = e.valid ? (32'd1 << e.idx) : 32'd0;
        if (e.on5) begin
            check({e.tag, ".valid"}, 32'(valid5), 32'(e.valid));
            if (e.valid) check({e.tag, ".idx"}, 32'(idx5), 32'(e.idx));
            check({e.tag, ".gnt"}, 32'(gnt5), exp_gnt);
        end else begin
            check({e.tag, ".valid"}, 32'(valid4), 32'(e.valid));
            if (e.valid) check({e.tag, ".idx"}, 32'(idx4), 32'(e.idx));
            check({e.tag, ".gnt"}, 32'(gnt4), exp_gnt);
        end
    endtask

    // Inputs are already driven; queue the expectation, take one edge, then score it.
    task automatic step(input string tag, input bit on5, input bit v, input int idx);
        exp_t e;
        e.tag   = tag;
        e.on5   = on5;
        e.valid = v;
        e.idx   = idx;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic drive4(input logic [3:0] req, input logic [3:0] mask,
                          input logic ready, input logic last);
        req4   = req;
        mask4  = mask;
        ready4 = ready;
        last4  = last;
    endtask

    task automatic do_reset4();
        drive4(4'b0000, 4'b0000, 1'b0, 1'b0);
        rst4_n = 1'b0;
        @(posedge clk);
        #1;
        rst4_n = 1'b1;
    endtask

    initial begin
        rst4_n = 1'b0;
        rst5_n = 1'b0;
        drive4(4'b0000, 4'b0000, 1'b0, 1'b0);
        req5 = '0; mask5 = '0; ready5 = 1'b0; last5 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst4.valid", 32'(valid4), 32'd0);
        check("rst4.gnt",   32'(gnt4),   32'd0);
        check("rst4.idx",   32'(idx4),   32'd0);
        check("rst5.valid", 32'(valid5), 32'd0);
        check("rst5.idx",   32'(idx5),   32'd0);

        // Grant latency of one cycle after reset release, search starts at 0.
        rst4_n = 1'b1;
        drive4(4'b1010, 4'b0000, 1'b0, 1'b0);
        step("first_grant", 1'b0, 1'b1, 1);
        step("hold_no_ready", 1'b0, 1'b1, 1);
        drive4(4'b0000, 4'b0000, 1'b1, 1'b1);
        step("done_to_idle", 1'b0, 1'b0, 0);

        // Back-to-back single-beat transactions rotate through every requester.
        do_reset4();
        drive4(4'b1111, 4'b0000, 1'b1, 1'b1);
        step("rr0", 1'b0, 1'b1, 0);
        step("rr1", 1'b0, 1'b1, 1);
        step("rr2", 1'b0, 1'b1, 2);
        step("rr3", 1'b0, 1'b1, 3);
        step("rr4", 1'b0, 1'b1, 0);
        drive4(4'b0000, 4'b0000, 1'b1, 1'b1);
        step("rr_idle", 1'b0, 1'b0, 0);

        // Masked requesters never win; pointer now sits at 1.
        drive4(4'b1111, 4'b0101, 1'b1, 1'b1);
        step("mask_a", 1'b0, 1'b1, 1);
        step("mask_b", 1'b0, 1'b1, 3);
        step("mask_c", 1'b0, 1'b1, 1);
        step("mask_d", 1'b0, 1'b1, 3);
        drive4(4'b0101, 4'b0101, 1'b1, 1'b1);
        step("mask_none", 1'b0, 1'b0, 0);
        step("mask_none2", 1'b0, 1'b0, 0);

        // Three-beat lock on idx 2 with request dropped and mask raised mid-transfer.
        drive4(4'b0100, 4'b0000, 1'b0, 1'b0);
        step("lock_grant", 1'b0, 1'b1, 2);
        drive4(4'b0100, 4'b0000, 1'b1, 1'b0);
        step("lock_beat1", 1'b0, 1'b1, 2);
        drive4(4'b0000, 4'b0100, 1'b0, 1'b1);
        step("lock_stall1", 1'b0, 1'b1, 2);
        drive4(4'b1011, 4'b0100, 1'b0, 1'b0);
        step("lock_stall2", 1'b0, 1'b1, 2);
        drive4(4'b1011, 4'b0100, 1'b1, 1'b0);
        step("lock_beat2", 1'b0, 1'b1, 2);
        drive4(4'b1011, 4'b0100, 1'b1, 1'b1);
        step("lock_ptr3", 1'b0, 1'b1, 3);
        drive4(4'b0000, 4'b0000, 1'b1, 1'b1);
        step("lock_idle", 1'b0, 1'b0, 0);

        // Asynchronous reset while holding idx 3 with a completing beat pending.
        drive4(4'b1000, 4'b0000, 1'b0, 1'b0);
        step("pre_rst", 1'b0, 1'b1, 3);
        drive4(4'b1000, 4'b0000, 1'b1, 1'b1);
        #2;
        rst4_n = 1'b0;
        #1;
        check("async_rst.valid", 32'(valid4), 32'd0);
        check("async_rst.gnt",   32'(gnt4),   32'd0);
        check("async_rst.idx",   32'(idx4),   32'd0);
        @(posedge clk);
        #1;
        check("in_rst.valid", 32'(valid4), 32'd0);
        rst4_n = 1'b1;
        drive4(4'b1001, 4'b0000, 1'b0, 1'b0);
        step("post_rst", 1'b0, 1'b1, 0);
        drive4(4'b1001, 4'b0000, 1'b1, 1'b1);
        step("post_rst_next", 1'b0, 1'b1, 3);

        // A lone eligible requester is re-granted on every completion.
        drive4(4'b0010, 4'b0000, 1'b1, 1'b1);
        step("single_a", 1'b0, 1'b1, 1);
        step("single_b", 1'b0, 1'b1, 1);
        step("single_c", 1'b0, 1'b1, 1);
        drive4(4'b0000, 4'b0000, 1'b1, 1'b1);
        step("single_idle", 1'b0, 1'b0, 0);

        // Five requesters: pointer wraps at 5, not at 8.
        rst5_n = 1'b1;
        req5 = 5'b10000;
        step("w5_grant4", 1'b1, 1'b1, 4);
        req5 = 5'b11111; ready5 = 1'b1; last5 = 1'b1;
        step("w5_wrap0", 1'b1, 1'b1, 0);
        step("w5_next1", 1'b1, 1'b1, 1);
        req5 = 5'b10000;
        step("w5_to4", 1'b1, 1'b1, 4);
        req5 = 5'b00001;
        step("w5_wrap_again", 1'b1, 1'b1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
